// File: rtl/ds_sample_scheduler.sv
// ds_sample_scheduler: buffers producer samples in a small FIFO and hands
// one to the modulator every (div+1) pulse boundaries. It primes the FIFO to
// half full before running, and falls back to STARVED when it runs dry.
// Optional feature macro: DS_SCHED_UNDERRUN_CNT_EN adds an 8-bit saturating
// underrun_count output.
module ds_sample_scheduler #(
   parameter int SAMPLE_BITS = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int DIV_BITS    = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [DIV_BITS-1:0]            div,
   input  logic [SAMPLE_BITS-1:0]         in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           pulse_done,
   output logic [SAMPLE_BITS-1:0]         u_out,
   output logic                           u_update,
   output logic                           underrun,
   output logic [1:0]                     state,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level
`ifdef DS_SCHED_UNDERRUN_CNT_EN
   ,
   output logic [7:0]                     underrun_count
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] HALF_LVL = LW'(FIFO_DEPTH / 2);
   localparam logic [SAMPLE_BITS-1:0] MIDSCALE = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRIME   = 2'd1,
      RUN     = 2'd2,
      STARVED = 2'd3
   } sched_state_t;

   sched_state_t cur_state;
   sched_state_t next_state;

   logic [SAMPLE_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [DIV_BITS-1:0]    pulse_cnt;

   logic do_push;
   logic do_pop;
   logic do_starve;
   logic cnt_clear;
   logic cnt_dec;

   assign state    = cur_state;
   assign in_ready = enable && !reset && (fifo_level < FULL_LVL);
   assign do_push  = in_valid && in_ready;

   // State register; any state falls back to IDLE while reset is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= next_state;
      end
   end

   // Next-state decode plus the pop/reload/starve decisions for this cycle.
   always_comb begin
      next_state = cur_state;
      do_pop     = 1'b0;
      do_starve  = 1'b0;
      cnt_clear  = 1'b0;
      cnt_dec    = 1'b0;
      if (!enable) begin
         next_state = IDLE;
      end else begin
         case (cur_state)
            IDLE: next_state = PRIME;
            PRIME, STARVED: begin
               if (fifo_level >= HALF_LVL) begin
                  next_state = RUN;
                  cnt_clear  = 1'b1;
               end
            end
            RUN: begin
               if (pulse_done) begin
                  if (pulse_cnt != '0) begin
                     cnt_dec = 1'b1;
                  end else if (fifo_level != '0) begin
                     do_pop = 1'b1;
                  end else begin
                     next_state = STARVED;
                     do_starve  = 1'b1;
                  end
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // FIFO pointers and occupancy; dropping enable flushes everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else if (!enable) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Sample storage needs no reset since the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Modulator-facing outputs, the pulse divider and the sticky underrun flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         u_out     <= MIDSCALE;
         u_update  <= 1'b0;
         underrun  <= 1'b0;
         pulse_cnt <= '0;
      end else if (!enable) begin
         u_update  <= (u_out != MIDSCALE);
         u_out     <= MIDSCALE;
         underrun  <= 1'b0;
         pulse_cnt <= '0;
      end else begin
         u_update <= do_pop;
         if (do_pop) begin
            u_out     <= mem[rd_ptr];
            pulse_cnt <= div;
         end else if (cnt_dec) begin
            pulse_cnt <= pulse_cnt - DIV_BITS'(1);
         end else if (cnt_clear) begin
            pulse_cnt <= '0;
         end
         if (do_starve) begin
            underrun <= 1'b1;
         end
      end
   end

`ifdef DS_SCHED_UNDERRUN_CNT_EN
   // Saturating count of RUN->STARVED transitions since the last flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         underrun_count <= '0;
      end else if (!enable) begin
         underrun_count <= '0;
      end else if (do_starve && (underrun_count != 8'hFF)) begin
         underrun_count <= underrun_count + 8'd1;
      end
   end
`endif

endmodule

// File: doc/ds_sample_scheduler.md
DS_SAMPLE_SCHEDULER -- requirements
Module: ds_sample_scheduler

Interface
REQ-001 Parameter SAMPLE_BITS, default 16: width of sample words and u_out.
REQ-002 Parameter FIFO_DEPTH, default 4: sample FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter DIV_BITS, default 8: width of the pulse divider.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = scheduler active; 0 = flush and idle.
REQ-007 div  input  DIV_BITS  modulator pulses per sample, minus one.
REQ-008 in_data  input  SAMPLE_BITS  sample word from the producer.
REQ-009 in_valid  input  1  in_data is valid.
REQ-010 in_ready  output  1  FIFO can accept a word this cycle.
REQ-011 pulse_done  input  1  one-cycle strobe from the modulator at each pulse boundary.
REQ-012 u_out  output  SAMPLE_BITS  current modulator input value (registered).
REQ-013 u_update  output  1  one-cycle strobe in the cycle u_out takes a new value.
REQ-014 underrun  output  1  sticky flag: FIFO ran dry while running.
REQ-015 state  output  2  FSM state: 0 IDLE, 1 PRIME, 2 RUN, 3 STARVED.
REQ-016 fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently held.

Function
REQ-017 Push: a word SHALL be written when in_valid && in_ready; in_ready = enable && (fifo_level < FIFO_DEPTH), derived from registered state only.
REQ-018 Simultaneous push and pop in one cycle SHALL both occur and leave fifo_level unchanged; push at full SHALL be impossible (in_ready=0).
REQ-019 IDLE: FIFO empty, pulse counter 0; enable=1 -> PRIME next cycle.
REQ-020 PRIME: no pops; when fifo_level >= FIFO_DEPTH/2 -> RUN with pulse counter loaded to 0.
REQ-021 RUN, pulse_done with counter != 0: counter decrements; u_out unchanged.
REQ-022 RUN, pulse_done with counter == 0 and FIFO non-empty: pop head to u_out, counter <= div, u_update=1; all three visible the cycle after pulse_done (latency 1).
REQ-023 RUN, pulse_done with counter == 0 and FIFO empty: -> STARVED, underrun <= 1, u_out holds its last value, no u_update.
REQ-024 STARVED: pulse_done ignored; when fifo_level >= FIFO_DEPTH/2 -> RUN with counter 0, so the next pulse_done pops.
REQ-025 div is sampled only at the counter reload; changing div mid-count SHALL NOT affect the count in progress.
REQ-026 div = 0 SHALL pop on every pulse_done.
REQ-027 enable=0 in any state -> IDLE next cycle: FIFO flushed, counter 0, underrun cleared, u_out <= midscale (1 << (SAMPLE_BITS-1)); u_update=1 only if u_out actually changed.
REQ-028 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range 0..FIFO_DEPTH inclusive.

Reset
REQ-029 While reset=1, immediately and independent of clk: state IDLE, fifo_level 0, pointers 0, counter 0, u_out midscale, u_update 0, underrun 0, in_ready 0.
REQ-030 Reset asserted mid-operation SHALL discard buffered samples; the first cycle after release with enable=1 SHALL enter PRIME.

Configuration
REQ-031 Macro DS_SCHED_UNDERRUN_CNT_EN defined: extra output underrun_count (8 bits), saturating at 255, incremented on each RUN->STARVED transition, cleared by reset or enable=0.
REQ-032 Macro not defined: underrun_count port and counter absent; all other behaviour identical.

Verification
REQ-033 Reset, enable=1, push 0x1000,0x2000 -> state PRIME->RUN once fifo_level=2; first pulse_done -> u_out=0x1000, u_update high one cycle later.
REQ-034 div=3, FIFO kept full, pulse_done every 10 cycles -> u_out changes on pulses 1,5,9,...; u_update exactly once per 4 pulses.
REQ-035 Stop pushing in RUN -> FIFO drains, next due pulse_done gives STARVED, underrun=1, u_out holds last sample; push 2 words -> RUN, next pulse_done pops.
REQ-036 FIFO full (fifo_level=4), pop and in_valid in same cycle -> in_ready=0, no push, level 3; next cycle push accepted, level 4.
REQ-037 enable dropped in RUN with 3 words queued -> next cycle IDLE, fifo_level 0, u_out=0x8000, u_update=1, underrun=0.
REQ-038 With DS_SCHED_UNDERRUN_CNT_EN, force 300 starvations -> underrun_count=255; without macro, same stimulus builds and only underrun=1.
